// File: rtl/uart_rx_8x.sv
// ---------------------------------------------------------------------------
// uart_rx_8x
//
// 8N1 UART receiver, LSB first, line idle high. It uses the shared 8x baud
// tick and a 3-sample majority vote in the middle of every bit.
// A correctly framed byte updates o_dout and pulses o_rx_done for one clk.
// A stop bit sampled low pulses o_frame_err for one clk and leaves o_dout
// unchanged.
//
// Parameters:
//   SYNC_STAGES  number of flops in the rx synchronizer (minimum 2)
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   baud_tick    one-clk pulse at 8x the baud rate
//   rx           asynchronous serial input
//   o_dout       last correctly framed byte
//   o_rx_done    one-clk strobe when o_dout is updated
//   o_frame_err  one-clk strobe when the stop bit is sampled low
//   o_rx_busy    high whenever the receiver is not idle
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_8x #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx,
  output logic [7:0] o_dout,
  output logic       o_rx_done,
  output logic       o_frame_err,
  output logic       o_rx_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_s_d_q, rx_s_d_d;
  logic [2:0]             b_cnt_q, b_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             dout_q, dout_d;
  logic                   v2_q, v2_d;
  logic                   v3_q, v3_d;
  logic                   rx_done_q, rx_done_d;
  logic                   frame_err_q, frame_err_d;

  logic rx_s;
  logic fall;
  logic maj;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_s_d_q & ~rx_s;
  // The third vote is the live synchronized line on the b_cnt==4 tick.
  assign maj  = (v2_q & v3_q) | (v2_q & rx_s) | (v3_q & rx_s);

  // Next-state and datapath logic. Only the synchronizer and the edge
  // detector move between ticks; everything else waits for baud_tick.
  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], rx};
    rx_s_d_d    = rx_s;
    b_cnt_d     = b_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    dout_d      = dout_q;
    v2_d        = v2_q;
    v3_d        = v3_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    if (baud_tick && (state_q != IDLE)) begin
      if (b_cnt_q == 3'd2) v2_d = rx_s;
      if (b_cnt_q == 3'd3) v3_d = rx_s;
    end

    case (state_q)
      IDLE: begin
        b_cnt_d   = 3'd0;
        bit_cnt_d = 3'd0;
        // Only a falling edge arms the receiver, so a stuck-low line
        // cannot start back-to-back bogus frames.
        if (fall) state_d = START;
      end

      START: begin
        if (baud_tick) begin
          b_cnt_d = b_cnt_q + 3'd1;
          if ((b_cnt_q == 3'd4) && maj) begin
            state_d = IDLE;
          end else if (b_cnt_q == 3'd7) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
      end

      DATA: begin
        if (baud_tick) begin
          b_cnt_d = b_cnt_q + 3'd1;
          if (b_cnt_q == 3'd4) shift_d = {maj, shift_q[7:1]};
          if (b_cnt_q == 3'd7) begin
            if (bit_cnt_q == 3'd7) state_d = STOP;
            else                   bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      STOP: begin
        // Leave at mid-stop-bit so a start edge right after the stop bit
        // is still seen.
        if (baud_tick) begin
          b_cnt_d = b_cnt_q + 3'd1;
          if (b_cnt_q == 3'd4) begin
            state_d = IDLE;
            if (maj) begin
              dout_d    = shift_q;
              rx_done_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. The synchronizer resets to the idle
  // level so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync_q      <= '1;
      rx_s_d_q    <= 1'b1;
      b_cnt_q     <= 3'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      dout_q      <= 8'h00;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rx_s_d_q    <= rx_s_d_d;
      b_cnt_q     <= b_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      dout_q      <= dout_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_dout      = dout_q;
  assign o_rx_done   = rx_done_q;
  assign o_frame_err = frame_err_q;
  assign o_rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_8x.sv
`timescale 1ns/1ps

module tb_uart_rx_8x;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic [7:0] o_dout;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_rx_busy;

  int checks   = 0;
  int failures = 0;

  uart_rx_8x #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .o_dout     (o_dout),
    .o_rx_done  (o_rx_done),
    .o_frame_err(o_frame_err),
    .o_rx_busy  (o_rx_busy)
  );

  always #5 clk = ~clk;

  // Tick generator: one-clk pulse every tick_div clocks, changed 1 ns
  // after the rising edge so the DUT sees a stable value.
  int tick_div = 16;
  bit tick_en  = 1'b0;
  int tick_cnt = 0;

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!tick_en) begin
        baud_tick = 1'b0;
        tick_cnt  = 0;
      end else begin
        tick_cnt++;
        if (tick_cnt >= tick_div) begin
          tick_cnt  = 0;
          baud_tick = 1'b1;
        end else begin
          baud_tick = 1'b0;
        end
      end
    end
  end

  // Output monitor: cumulative pulse counts, byte seen with each done
  // pulse, busy rises and the length of the last busy-low gap.
  int         done_cnt  = 0;
  int         ferr_cnt  = 0;
  int         both_cnt  = 0;
  int         rise_cnt  = 0;
  int         low_run   = 0;
  int         last_gap  = 0;
  logic       prev_busy = 1'b0;
  logic [7:0] done_data[$];

  always @(negedge clk) begin
    if (o_rx_done) begin
      done_cnt++;
      done_data.push_back(o_dout);
    end
    if (o_frame_err) ferr_cnt++;
    if (o_rx_done && o_frame_err) both_cnt++;
    if (o_rx_busy && !prev_busy) begin
      rise_cnt++;
      last_gap = low_run;
    end
    if (!o_rx_busy) low_run++;
    else            low_run = 0;
    prev_busy = o_rx_busy;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         glitch_bit;
    int         glitch_off;
    int         exp_done;
    int         exp_ferr;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Wait for n ticks; returns at the rising edge that samples the n-th tick.
  task automatic waitTicks(input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      @(posedge clk);
      while (baud_tick !== 1'b1 && guard < 1000) begin
        @(posedge clk);
        guard++;
      end
      if (guard >= 1000) begin
        checks++;
        failures++;
        $display("[TB] FAIL tick_timeout: got no tick, expected tick within 1000 clk");
      end
    end
  endtask

  task automatic driveBit(input logic value, input int n_ticks);
    #2 rx = value;
    waitTicks(n_ticks);
  endtask

  // Sends one frame; optionally inverts data bit gbit for one tick,
  // starting goff ticks into that bit.
  task automatic sendFrame(input logic [7:0] data, input logic stop_bit,
                           input int gbit, input int goff);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      if (gbit >= 0 && b == gbit + 1) begin
        driveBit(bits[b], goff);
        driveBit(~bits[b], 1);
        driveBit(bits[b], 8 - goff - 1);
      end else begin
        driveBit(bits[b], 8);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    sendFrame(v.data, v.stop_bit, v.glitch_bit, v.glitch_off);
    driveBit(1'b1, 16);
  endtask

  initial begin
    int base_done;
    int base_ferr;
    int base_rise;
    logic [7:0] prev_dout;

    vecs[0] = '{8'h55, 1'b1, -1, 0, 1, 0, 8'h55};
    vecs[1] = '{8'hA5, 1'b1, -1, 0, 1, 0, 8'hA5};
    vecs[2] = '{8'h3C, 1'b1, -1, 0, 1, 0, 8'h3C};
    vecs[3] = '{8'h00, 1'b1,  2, 3, 1, 0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1,  5, 4, 1, 0, 8'hFF};
    vecs[5] = '{8'h0F, 1'b1,  6, 2, 1, 0, 8'h0F};
    vecs[6] = '{8'h81, 1'b1, -1, 0, 1, 0, 8'h81};
    vecs[7] = '{8'hFF, 1'b0, -1, 0, 0, 1, 8'h81};
    vecs[8] = '{8'h6E, 1'b1, -1, 0, 1, 0, 8'h6E};

    // Reset state
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_dout",  int'(o_dout),      0);
    checkOutput("reset_done",  int'(o_rx_done),   0);
    checkOutput("reset_ferr",  int'(o_frame_err), 0);
    checkOutput("reset_busy",  int'(o_rx_busy),   0);
    tick_en = 1'b1;
    waitTicks(2);

    // Table of single frames
    for (int i = 0; i < 9; i++) begin
      base_done = done_cnt;
      base_ferr = ferr_cnt;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done", i), done_cnt - base_done, vecs[i].exp_done);
      checkOutput($sformatf("vec%0d_ferr", i), ferr_cnt - base_ferr, vecs[i].exp_ferr);
      checkOutput($sformatf("vec%0d_dout", i), int'(o_dout), int'(vecs[i].exp_dout));
      waitTicks(1);
    end

    // Back-to-back frames with no idle gap
    base_done = done_cnt;
    base_ferr = ferr_cnt;
    sendFrame(8'hA5, 1'b1, -1, 0);
    sendFrame(8'h3C, 1'b1, -1, 0);
    driveBit(1'b1, 16);
    @(negedge clk);
    checkOutput("b2b_done", done_cnt - base_done, 2);
    checkOutput("b2b_ferr", ferr_cnt - base_ferr, 0);
    if (done_data.size() >= base_done + 2) begin
      checkOutput("b2b_first",  int'(done_data[base_done]),     8'hA5);
      checkOutput("b2b_second", int'(done_data[base_done + 1]), 8'h3C);
    end else begin
      checkOutput("b2b_pulses_recorded", done_data.size() - base_done, 2);
    end
    checkOutput("b2b_gap_le_4_ticks", int'(last_gap <= 4 * tick_div), 1);
    waitTicks(1);

    // False start: 2-tick low glitch
    prev_dout = o_dout;
    base_done = done_cnt;
    base_ferr = ferr_cnt;
    base_rise = rise_cnt;
    driveBit(1'b0, 2);
    driveBit(1'b1, 4);
    @(negedge clk);
    checkOutput("false_busy_low", int'(o_rx_busy), 0);
    checkOutput("false_start_entered", rise_cnt - base_rise, 1);
    checkOutput("false_done", done_cnt - base_done, 0);
    checkOutput("false_ferr", ferr_cnt - base_ferr, 0);
    checkOutput("false_dout", int'(o_dout), int'(prev_dout));
    waitTicks(8);

    // Framing error, then line held low for 3 bit times
    prev_dout = o_dout;
    base_done = done_cnt;
    base_ferr = ferr_cnt;
    base_rise = rise_cnt;
    sendFrame(8'hFF, 1'b0, -1, 0);
    driveBit(1'b0, 24);
    @(negedge clk);
    checkOutput("ferr_pulses", ferr_cnt - base_ferr, 1);
    checkOutput("ferr_done",   done_cnt - base_done, 0);
    checkOutput("ferr_dout",   int'(o_dout), int'(prev_dout));
    checkOutput("ferr_no_rearm_busy", int'(o_rx_busy), 0);
    checkOutput("ferr_no_rearm_rises", rise_cnt - base_rise, 1);
    waitTicks(1);
    driveBit(1'b1, 16);
    base_done = done_cnt;
    sendFrame(8'h5A, 1'b1, -1, 0);
    driveBit(1'b1, 16);
    @(negedge clk);
    checkOutput("rearm_done", done_cnt - base_done, 1);
    checkOutput("rearm_dout", int'(o_dout), 8'h5A);
    waitTicks(1);

    // Continuous ticks
    tick_div = 1;
    waitTicks(2);
    base_done = done_cnt;
    base_ferr = ferr_cnt;
    sendFrame(8'hC3, 1'b1, -1, 0);
    driveBit(1'b1, 16);
    @(negedge clk);
    checkOutput("cont_done", done_cnt - base_done, 1);
    checkOutput("cont_ferr", ferr_cnt - base_ferr, 0);
    checkOutput("cont_dout", int'(o_dout), 8'hC3);
    tick_div = 16;
    waitTicks(2);

    // Reset during bit 4 of 0x12
    driveBit(1'b0, 8);
    for (int b = 0; b < 4; b++) begin
      logic [7:0] d12;
      d12 = 8'h12;
      driveBit(d12[b], 8);
    end
    driveBit(1'b1, 4);
    @(negedge clk);
    checkOutput("mid_busy_before_rst", int'(o_rx_busy), 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_dout", int'(o_dout),      0);
    checkOutput("rst_mid_done", int'(o_rx_done),   0);
    checkOutput("rst_mid_ferr", int'(o_frame_err), 0);
    checkOutput("rst_mid_busy", int'(o_rx_busy),   0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base_done = done_cnt;
    base_ferr = ferr_cnt;
    driveBit(1'b1, 16);
    @(negedge clk);
    checkOutput("post_rst_no_pulse", done_cnt - base_done + ferr_cnt - base_ferr, 0);
    waitTicks(1);
    sendFrame(8'h34, 1'b1, -1, 0);
    driveBit(1'b1, 16);
    @(negedge clk);
    checkOutput("post_rst_done", done_cnt - base_done, 1);
    checkOutput("post_rst_ferr", ferr_cnt - base_ferr, 0);
    checkOutput("post_rst_dout", int'(o_dout), 8'h34);

    checkOutput("done_and_ferr_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
